eac_sum_resolver: RTL

Sequential consumer of the end-around-carry adder's candidate results in the MAC datapath. It takes the true-sum and inverted-sum candidates plus the effective-operation sign and selects the positive magnitude and result sign. It then counts leading zeros iteratively, one chunk per cycle, and left-normalizes the magnitude before handing it to rounding over a valid/ready handshake.

---
 rtl/eac_sum_resolver_pkg.sv | 30 +++
 rtl/eac_sum_resolver_chunk_lzc.sv | 23 ++
 rtl/eac_sum_resolver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/eac_sum_resolver_pkg.sv
// Purpose: shared constants for the EAC sum resolver (mantissa width, chunk
//          geometry, derived widths) and the resolver FSM state encoding.
// Ports:   none (package).
package eac_sum_resolver_pkg;

  localparam int PARM_MANT  = 23;
  localparam int PARM_CHUNK = 8;

  localparam int W      = 2 * PARM_MANT + 2;                     // candidate sum width
  localparam int M      = W + 1;                                 // magnitude width
  localparam int NCHUNK = (M + PARM_CHUNK - 1) / PARM_CHUNK;     // scan steps
  localparam int PADW   = NCHUNK * PARM_CHUNK;                   // magnitude padded to whole chunks
  localparam int PAD    = PADW - M;                              // zero bits appended below bit 0
  localparam int LZC_W  = $clog2(M + 1);
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNT_W  = (PARM_CHUNK > 1) ? $clog2(PARM_CHUNK) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SCAN  = ST_SCAN,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/eac_sum_resolver_chunk_lzc.sv
// Purpose: leading-zero count of one PARM_CHUNK-wide slice, combinational.
// Ports:   chunk_i slice (MSB first); nz_o slice has a set bit;
//          cnt_o zeros above the first set bit (don't-care when nz_o=0).
module eac_sum_resolver_chunk_lzc
  import eac_sum_resolver_pkg::*;
(
  input  logic [PARM_CHUNK-1:0] chunk_i,
  output logic                  nz_o,
  output logic [CNT_W-1:0]      cnt_o
);

  always_comb begin
    nz_o  = |chunk_i;
    cnt_o = '0;
    // Walk upward so the highest set bit is the last one to write cnt_o.
    for (int i = 0; i < PARM_CHUNK; i++) begin
      if (chunk_i[i]) begin
        cnt_o = CNT_W'(PARM_CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/eac_sum_resolver.sv
// Purpose: selects the positive magnitude/sign from the EAC adder candidates,
//          finds leading zeros one chunk per cycle, left-normalizes the result.
// Ports:   clk_i/rst_ni (sync, active-low); in_valid_i/in_ready_o + candidate
//          inputs; out_valid_o/out_ready_i + norm_mant_o, lzc_o, zero_o, sign_o.
module eac_sum_resolver
  import eac_sum_resolver_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     low_sum_i,
  input  logic             low_carry_i,
  input  logic [W-1:0]     low_sum_inv_i,
  input  logic             Sub_Sign_i,
  input  logic             Sign_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [M-1:0]     norm_mant_o,
  output logic [LZC_W-1:0] lzc_o,
  output logic             zero_o,
  output logic             sign_o
);

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [M-1:0]        mag_q;
  logic                sign_w_q;
  logic [CIDX_W-1:0]   cidx_q;
  logic [LZC_W-1:0]    lzc_w_q;
  logic                zero_w_q;
  logic [M-1:0]        norm_q;
  logic [LZC_W-1:0]    lzc_q;
  logic                zero_q;
  logic                sign_q;

  logic [M-1:0]        mag_d;
  logic                sign_d;
  logic [PADW-1:0]     padded;
  logic [PADW-1:0]     win;
  logic [PARM_CHUNK-1:0] chunk;
  logic                chk_nz;
  logic [CNT_W-1:0]    chk_cnt;

  // Candidate selection: a subtraction without carry-out means the true sum
  // went negative, so the inverted candidate is the magnitude and sign flips.
  always_comb begin
    mag_d  = {low_carry_i, low_sum_i};
    sign_d = Sign_i;
    if (Sub_Sign_i) begin
      if (low_carry_i) begin
        mag_d = {1'b0, low_sum_i};
      end else begin
        mag_d  = {1'b0, low_sum_inv_i};
        sign_d = ~Sign_i;
      end
    end
  end

  // Chunk mux: left-justify into whole chunks (zero pad below bit 0), then
  // bring chunk cidx_q to the top.
  assign padded = PADW'(mag_q) << PAD;
  assign win    = padded << (cidx_q * PARM_CHUNK);
  assign chunk  = win[PADW-1 -: PARM_CHUNK];

  eac_sum_resolver_chunk_lzc u_chunk_lzc (
    .chunk_i (chunk),
    .nz_o    (chk_nz),
    .cnt_o   (chk_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      sign_w_q    <= 1'b0;
      cidx_q      <= '0;
      lzc_w_q     <= '0;
      zero_w_q    <= 1'b0;
      norm_q      <= '0;
      lzc_q       <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            mag_q      <= mag_d;
            sign_w_q   <= sign_d;
            cidx_q     <= '0;
            zero_w_q   <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (chk_nz) begin
            lzc_w_q <= LZC_W'(cidx_q) * LZC_W'(PARM_CHUNK) + LZC_W'(chk_cnt);
            state_q <= S_SHIFT;
          end else if (cidx_q == CIDX_W'(NCHUNK - 1)) begin
            lzc_w_q  <= LZC_W'(M);
            zero_w_q <= 1'b1;
            state_q  <= S_SHIFT;
          end else begin
            cidx_q <= cidx_q + CIDX_W'(1);
          end
        end
        S_SHIFT: begin
          // A shift by M clears the word, which is the zero-magnitude result.
          norm_q      <= mag_q << lzc_w_q;
          lzc_q       <= lzc_w_q;
          zero_q      <= zero_w_q;
          sign_q      <= sign_w_q & ~zero_w_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign norm_mant_o = norm_q;
  assign lzc_o       = lzc_q;
  assign zero_o      = zero_q;
  assign sign_o      = sign_q;

endmodule
